// File: rtl/axi_xbar_aw_w_arbiter.sv
// axi_xbar_aw_w_arbiter
// Per-slave-port arbiter of the AXI crossbar. Shares one slave AW channel
// among NUM_MST master AW channels with locked round-robin, records every
// granted master in an in-order W-route FIFO and steers the W channel from
// the master at the FIFO head until its WLAST beat.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   mst_aw_valid_i/payload_i per-master AW requests (master k in slice k)
//   mst_aw_ready_o           per-master AWREADY
//   slv_aw_valid_o/payload_o muxed AW towards the slave port
//   slv_aw_mst_idx_o         granted master index (ID prefix, B routing)
//   slv_aw_ready_i           slave AWREADY
//   mst_w_valid_i/last_i/payload_i  per-master W channels
//   mst_w_ready_o            per-master WREADY
//   slv_w_valid_o/last_o/payload_o  muxed W towards the slave port
//   slv_w_ready_i            slave WREADY
//   w_fifo_count_o           W-route FIFO occupancy
module axi_xbar_aw_w_arbiter #(
   parameter int unsigned NUM_MST      = 4,
   parameter int unsigned AW_PAYLOAD_W = 64,
   parameter int unsigned W_PAYLOAD_W  = 72,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_MST-1:0]               mst_aw_valid_i,
   input  logic [NUM_MST*AW_PAYLOAD_W-1:0]  mst_aw_payload_i,
   output logic [NUM_MST-1:0]               mst_aw_ready_o,
   output logic                             slv_aw_valid_o,
   output logic [AW_PAYLOAD_W-1:0]          slv_aw_payload_o,
   output logic [$clog2(NUM_MST)-1:0]       slv_aw_mst_idx_o,
   input  logic                             slv_aw_ready_i,
   input  logic [NUM_MST-1:0]               mst_w_valid_i,
   input  logic [NUM_MST-1:0]               mst_w_last_i,
   input  logic [NUM_MST*W_PAYLOAD_W-1:0]   mst_w_payload_i,
   output logic [NUM_MST-1:0]               mst_w_ready_o,
   output logic                             slv_w_valid_o,
   output logic                             slv_w_last_o,
   output logic [W_PAYLOAD_W-1:0]           slv_w_payload_o,
   input  logic                             slv_w_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]      w_fifo_count_o
);

   localparam int unsigned IDX_W = $clog2(NUM_MST);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [0:0]       ST_IDLE   = 1'b0;
   localparam logic [0:0]       ST_LOCKED = 1'b1;
   localparam logic [IDX_W-1:0] LAST_MST  = IDX_W'(NUM_MST - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] route_q [FIFO_DEPTH];
   logic [IDX_W-1:0] route_d [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

   logic             found_s;
   logic [IDX_W-1:0] winner_s;
   logic [PTR_W:0]   count_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [IDX_W-1:0] head_s;
   logic             push_s;
   logic             pop_s;
   logic             aw_hs_s;

   // The extra pointer bit tells a full FIFO apart from an empty one.
   assign count_s        = wr_ptr_q - rd_ptr_q;
   assign fifo_full_s    = (count_s == CNT_FULL);
   assign fifo_empty_s   = (wr_ptr_q == rd_ptr_q);
   assign head_s         = route_q[rd_ptr_q[PTR_W-1:0]];
   assign w_fifo_count_o = count_s;
   assign aw_hs_s        = slv_aw_valid_o & slv_aw_ready_i;
   assign pop_s          = slv_w_valid_o & slv_w_ready_i & slv_w_last_o;

   // Round-robin search: first valid master after rr_ptr, wrapping at NUM_MST-1.
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand     = rr_ptr_q;
      found_s  = 1'b0;
      winner_s = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (cand == LAST_MST) begin
            cand = '0;
         end else begin
            cand = cand + IDX_ONE;
         end
         if (!found_s && mst_aw_valid_i[cand]) begin
            found_s  = 1'b1;
            winner_s = cand;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // AW steering: only the locked master sees the slave and vice versa.
   always_comb begin
      slv_aw_valid_o   = 1'b0;
      slv_aw_payload_o = '0;
      slv_aw_mst_idx_o = '0;
      mst_aw_ready_o   = '0;
      if (state_q == ST_LOCKED) begin
         slv_aw_valid_o          = mst_aw_valid_i[grant_q];
         slv_aw_mst_idx_o        = grant_q;
         mst_aw_ready_o[grant_q] = slv_aw_ready_i;
         for (int k = 0; k < NUM_MST; k++) begin
            slv_aw_payload_o = slv_aw_payload_o |
               ({AW_PAYLOAD_W{grant_q == IDX_W'(k)}} &
                mst_aw_payload_i[k*AW_PAYLOAD_W +: AW_PAYLOAD_W]);
         end
      end else begin
         slv_aw_valid_o = 1'b0;
      end
   end

   // AW FSM: grant in IDLE when a FIFO slot is free, hold grant until handshake.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      push_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found_s && !fifo_full_s) begin
               grant_d = winner_s;
               state_d = ST_LOCKED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (aw_hs_s) begin
               push_s   = 1'b1;
               rr_ptr_d = grant_q;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // W-route FIFO next state: push the granted index, pop on the WLAST beat.
   always_comb begin
      route_d  = route_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         route_d[wr_ptr_q[PTR_W-1:0]] = grant_q;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // W steering from the registered FIFO head; no path from the AW channel.
   always_comb begin
      slv_w_valid_o   = 1'b0;
      slv_w_last_o    = 1'b0;
      slv_w_payload_o = '0;
      mst_w_ready_o   = '0;
      if (!fifo_empty_s) begin
         slv_w_valid_o         = mst_w_valid_i[head_s];
         slv_w_last_o          = mst_w_last_i[head_s];
         mst_w_ready_o[head_s] = slv_w_ready_i;
         for (int k = 0; k < NUM_MST; k++) begin
            slv_w_payload_o = slv_w_payload_o |
               ({W_PAYLOAD_W{head_s == IDX_W'(k)}} &
                mst_w_payload_i[k*W_PAYLOAD_W +: W_PAYLOAD_W]);
         end
      end else begin
         slv_w_valid_o = 1'b0;
      end
   end

   // State registers; rr_ptr starts at the last master so master 0 wins first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= LAST_MST;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            route_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         route_q  <= route_d;
      end
   end

endmodule

// File: tb/tb_axi_xbar_aw_w_arbiter.sv
// Scoreboard bench for axi_xbar_aw_w_arbiter: random AW/W traffic from four
// masters, expected grants/beats queued at issue time and compared by a
// monitor sampling on the falling clock edge.
module tb_axi_xbar_aw_w_arbiter;

   localparam int NM    = 4;
   localparam int AWW   = 64;
   localparam int WW    = 72;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic          last;
      logic [WW-1:0] data;
   } w_beat_t;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [NM-1:0]     mst_aw_valid_i = '0;
   logic [NM*AWW-1:0] mst_aw_payload_i = '0;
   logic [NM-1:0]     mst_aw_ready_o;
   logic              slv_aw_valid_o;
   logic [AWW-1:0]    slv_aw_payload_o;
   logic [1:0]        slv_aw_mst_idx_o;
   logic              slv_aw_ready_i = 1'b0;
   logic [NM-1:0]     mst_w_valid_i = '0;
   logic [NM-1:0]     mst_w_last_i = '0;
   logic [NM*WW-1:0]  mst_w_payload_i = '0;
   logic [NM-1:0]     mst_w_ready_o;
   logic              slv_w_valid_o;
   logic              slv_w_last_o;
   logic [WW-1:0]     slv_w_payload_o;
   logic              slv_w_ready_i = 1'b0;
   logic [2:0]        w_fifo_count_o;

   axi_xbar_aw_w_arbiter #(
      .NUM_MST(NM), .AW_PAYLOAD_W(AWW), .W_PAYLOAD_W(WW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mst_aw_valid_i(mst_aw_valid_i), .mst_aw_payload_i(mst_aw_payload_i),
      .mst_aw_ready_o(mst_aw_ready_o),
      .slv_aw_valid_o(slv_aw_valid_o), .slv_aw_payload_o(slv_aw_payload_o),
      .slv_aw_mst_idx_o(slv_aw_mst_idx_o), .slv_aw_ready_i(slv_aw_ready_i),
      .mst_w_valid_i(mst_w_valid_i), .mst_w_last_i(mst_w_last_i),
      .mst_w_payload_i(mst_w_payload_i), .mst_w_ready_o(mst_w_ready_o),
      .slv_w_valid_o(slv_w_valid_o), .slv_w_last_o(slv_w_last_o),
      .slv_w_payload_o(slv_w_payload_o), .slv_w_ready_i(slv_w_ready_i),
      .w_fifo_count_o(w_fifo_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Stimulus queues (what each master still has to send) and expected queues.
   logic [AWW-1:0] aw_q     [NM][$];
   logic [AWW-1:0] exp_aw_q [NM][$];
   w_beat_t        w_q      [NM][$];
   w_beat_t        exp_w_q  [NM][$];
   int             route_q  [$];

   int checks = 0;
   int errors = 0;
   int aw_rdy_pct = 80;
   int w_rdy_pct  = 70;

   // Reference state: last granted master and what was seen one cycle ago.
   int            model_rr    = NM - 1;
   int            lock_idx    = 0;
   logic          prev_aw_v   = 1'b0;
   logic          prev_aw_hs  = 1'b0;
   logic [NM-1:0] prev_mvalid = '0;
   int            prev_cnt    = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NM-1:0] v, input int last);
      for (int i = 1; i <= NM; i++) begin
         if (v[(last + i) % NM]) return (last + i) % NM;
      end
      return -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_aw_valid"},   slv_aw_valid_o,   0);
      check({tag, "_aw_payload"}, slv_aw_payload_o, 0);
      check({tag, "_aw_ready"},   mst_aw_ready_o,   0);
      check({tag, "_w_valid"},    slv_w_valid_o,    0);
      check({tag, "_w_last"},     slv_w_last_o,     0);
      check({tag, "_w_payload"},  slv_w_payload_o,  0);
      check({tag, "_w_ready"},    mst_w_ready_o,    0);
      check({tag, "_count"},      w_fifo_count_o,   0);
   endtask

   task automatic new_txn(input int k);
      logic [AWW-1:0] p;
      w_beat_t        b;
      int             len;
      p = {$urandom(), $urandom()};
      aw_q[k].push_back(p);
      exp_aw_q[k].push_back(p);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
         b.data = WW'({$urandom(), $urandom(), $urandom()});
         b.last = (i == len - 1);
         w_q[k].push_back(b);
         exp_w_q[k].push_back(b);
      end
   endtask

   task automatic gen_cycles(input int n, input int gen_pct);
      int k;
      repeat (n) begin
         @(posedge clk_i);
         #2;
         if ($urandom_range(0, 99) < gen_pct) begin
            k = $urandom_range(0, NM - 1);
            if (aw_q[k].size() < 3) new_txn(k);
         end
      end
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < NM; k++) begin
         if (aw_q[k].size() != 0 || w_q[k].size() != 0) return 1'b0;
      end
      return route_q.size() == 0;
   endfunction

   // Master/slave driver: AXI-legal valids (held until handshake), random readies.
   initial begin : driver
      logic [NM-1:0]  aw_hs_v;
      logic [NM-1:0]  w_hs_v;
      logic [AWW-1:0] dummy_aw;
      w_beat_t        dummy_w;
      forever begin
         @(negedge clk_i);
         aw_hs_v = mst_aw_valid_i & mst_aw_ready_o;
         w_hs_v  = mst_w_valid_i & mst_w_ready_o;
         @(posedge clk_i);
         #1;
         if (rst_i) begin
            aw_hs_v = '0;
            w_hs_v  = '0;
         end
         for (int k = 0; k < NM; k++) begin
            if (aw_hs_v[k] && aw_q[k].size() > 0) dummy_aw = aw_q[k].pop_front();
            if (w_hs_v[k] && w_q[k].size() > 0) dummy_w = w_q[k].pop_front();
            if (aw_q[k].size() == 0) mst_aw_valid_i[k] = 1'b0;
            else if (!(mst_aw_valid_i[k] && !aw_hs_v[k]))
               mst_aw_valid_i[k] = ($urandom_range(0, 99) < 60);
            mst_aw_payload_i[k*AWW +: AWW] = (aw_q[k].size() > 0) ? aw_q[k][0] : '0;
            if (w_q[k].size() == 0) mst_w_valid_i[k] = 1'b0;
            else if (!(mst_w_valid_i[k] && !w_hs_v[k]))
               mst_w_valid_i[k] = ($urandom_range(0, 99) < 60);
            mst_w_last_i[k]             = (w_q[k].size() > 0) ? w_q[k][0].last : 1'b0;
            mst_w_payload_i[k*WW +: WW] = (w_q[k].size() > 0) ? w_q[k][0].data : '0;
         end
         slv_aw_ready_i = ($urandom_range(0, 99) < aw_rdy_pct);
         slv_w_ready_i  = ($urandom_range(0, 99) < w_rdy_pct);
      end
   end

   // Monitor: compares DUT outputs with the reference and retires expected items.
   initial begin : monitor
      logic          exp_aw_v;
      logic          aw_hs;
      logic          exp_wv;
      logic [NM-1:0] oh;
      int            cnt_now;
      int            h;
      w_beat_t       b;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            prev_aw_v   = 1'b0;
            prev_aw_hs  = 1'b0;
            prev_mvalid = '0;
            prev_cnt    = 0;
         end else begin
            cnt_now = route_q.size();
            // A grant is held until its handshake; otherwise a new one is made
            // one cycle after a request seen while a route slot was free.
            if (prev_aw_v) begin
               exp_aw_v = !prev_aw_hs;
            end else begin
               exp_aw_v = (prev_mvalid != 0) && (prev_cnt < DEPTH);
               if (exp_aw_v) lock_idx = rr_pick(prev_mvalid, model_rr);
            end
            check("aw_valid", slv_aw_valid_o, exp_aw_v);
            oh = '0;
            if (exp_aw_v && slv_aw_ready_i) oh[lock_idx] = 1'b1;
            check("aw_ready", mst_aw_ready_o, oh);
            if (exp_aw_v) check("aw_idx", slv_aw_mst_idx_o, lock_idx);
            aw_hs = exp_aw_v && slv_aw_ready_i;
            if (aw_hs) begin
               if (exp_aw_q[lock_idx].size() > 0) begin
                  check("aw_payload", slv_aw_payload_o, exp_aw_q[lock_idx].pop_front());
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL aw_unexpected: master %0d has no pending AW", lock_idx);
               end
               model_rr = lock_idx;
            end
            check("count", w_fifo_count_o, cnt_now);
            oh     = '0;
            exp_wv = 1'b0;
            h      = 0;
            if (cnt_now > 0) begin
               h      = route_q[0];
               exp_wv = mst_w_valid_i[h];
               if (slv_w_ready_i) oh[h] = 1'b1;
            end
            check("w_valid", slv_w_valid_o, exp_wv);
            check("w_ready", mst_w_ready_o, oh);
            if (exp_wv && exp_w_q[h].size() > 0) begin
               b = exp_w_q[h][0];
               check("w_payload", slv_w_payload_o, b.data);
               check("w_last", slv_w_last_o, b.last);
               if (slv_w_ready_i) begin
                  b = exp_w_q[h].pop_front();
                  if (b.last) h = route_q.pop_front();
               end
            end
            if (aw_hs) route_q.push_back(lock_idx);
            prev_aw_v   = exp_aw_v;
            prev_aw_hs  = aw_hs;
            prev_mvalid = mst_aw_valid_i;
            prev_cnt    = cnt_now;
         end
      end
   end

   // Main sequence: reset, random phases, mid-run reset, drain, summary.
   initial begin : main
      bit reached;
      #2;
      check_reset_outputs("rst");
      repeat (2) @(negedge clk_i);
      #2 rst_i = 1'b0;

      aw_rdy_pct = 80; w_rdy_pct = 70;
      gen_cycles(600, 40);
      aw_rdy_pct = 90; w_rdy_pct = 10;
      gen_cycles(300, 60);

      reached = 1'b0;
      for (int i = 0; i < 500 && !reached; i++) begin
         @(posedge clk_i);
         #3;
         if (route_q.size() >= 2) reached = 1'b1;
      end
      if (!reached) begin
         checks++;
         errors++;
         $display("FAIL midrst_setup: route occupancy never reached 2");
      end
      rst_i = 1'b1;
      #1;
      check_reset_outputs("midrst");
      for (int k = 0; k < NM; k++) begin
         aw_q[k].delete();
         exp_aw_q[k].delete();
         w_q[k].delete();
         exp_w_q[k].delete();
      end
      route_q.delete();
      model_rr        = NM - 1;
      mst_aw_valid_i  = '0;
      mst_w_valid_i   = '0;
      repeat (3) @(negedge clk_i);
      #2 rst_i = 1'b0;

      aw_rdy_pct = 70; w_rdy_pct = 60;
      gen_cycles(500, 45);

      aw_rdy_pct = 100; w_rdy_pct = 100;
      reached = 1'b0;
      for (int i = 0; i < 2000 && !reached; i++) begin
         @(posedge clk_i);
         #3;
         if (all_empty()) reached = 1'b1;
      end
      checks++;
      if (!reached) begin
         errors++;
         $display("FAIL drain: traffic still outstanding after 2000 cycles");
      end
      repeat (3) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
